// File: rtl/vrf_writeback_arb_if.sv
// Handshake/bus bundle between the vector register file writeback arbiter and its neighbours:
// issue stage, ALU result pipe, LSU load returns and the register file write port.
interface vrf_writeback_arb_if #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 2
);
   logic              iss_valid;
   logic [4:0]        iss_waddr;
   logic [31:0]       busy;

   logic              alu_valid;
   logic [4:0]        alu_waddr;
   logic [DATA_W-1:0] alu_wdata;
   logic              alu_stall;

   logic              lsu_valid;
   logic              lsu_ready;
   logic [4:0]        lsu_waddr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [CNT_W-1:0]  lsu_count;

   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   modport slave (
      input  iss_valid, iss_waddr,
      input  alu_valid, alu_waddr, alu_wdata,
      input  lsu_valid, lsu_waddr, lsu_wdata,
      output busy, alu_stall, lsu_ready, lsu_count,
      output rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output iss_valid, iss_waddr,
      output alu_valid, alu_waddr, alu_wdata,
      output lsu_valid, lsu_waddr, lsu_wdata,
      input  busy, alu_stall, lsu_ready, lsu_count,
      input  rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/vrf_writeback_arb.sv
// Sole VRF writer: ALU results (1 cycle) beat buffered LSU returns (min 2 cycles); LSU is
// backpressured by a full FIFO. Keeps the pending-write scoreboard. Option VWB_STARVE_EN adds anti-starvation.
module vrf_writeback_arb #(
   parameter int DATA_W     = 128,
   parameter int LSU_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   vrf_writeback_arb_if.slave  bus
);

   localparam int PTR_W = $clog2(LSU_DEPTH);
   localparam int CNT_W = $clog2(LSU_DEPTH) + 1;

   logic [4:0]        fifo_addr_q [LSU_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [LSU_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [31:0]       busy_q, busy_d;

   logic              fifo_empty;
   logic              fifo_ready;
   logic              push;
   logic              lsu_grant;
   logic              alu_grant;
   logic              stall_q;

   // Ready depends only on registered occupancy, so a full FIFO refuses a push even while popping.
   assign fifo_empty = (count_q == '0);
   assign fifo_ready = (count_q != CNT_W'(LSU_DEPTH));
   assign push       = bus.lsu_valid && fifo_ready;

   always_comb begin
      lsu_grant = 1'b0;
      alu_grant = 1'b0;
      if (!fifo_empty && (stall_q || !bus.alu_valid)) begin
         lsu_grant = 1'b1;
      end else if (bus.alu_valid) begin
         alu_grant = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (lsu_grant) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(lsu_grant);
   end

   always_comb begin
      rf_we_d    = alu_grant || lsu_grant;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (lsu_grant) begin
         rf_waddr_d = fifo_addr_q[rd_ptr_q];
         rf_wdata_d = fifo_data_q[rd_ptr_q];
      end else if (alu_grant) begin
         rf_waddr_d = bus.alu_waddr;
         rf_wdata_d = bus.alu_wdata;
      end
   end

   // Clear first, then set, so an issue to the register being written this edge stays pending.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_d) begin
         busy_d[rf_waddr_d] = 1'b0;
      end
      if (bus.iss_valid) begin
         busy_d[bus.iss_waddr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LSU_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.lsu_waddr;
            fifo_data_q[wr_ptr_q] <= bus.lsu_wdata;
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

`ifdef VWB_STARVE_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic [SC_W-1:0] starve_q, starve_d;
   logic            stall_d;

   // Counts consecutive cycles the queued load lost to the ALU; saturates at the threshold.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || lsu_grant) begin
         starve_d = '0;
      end else if (alu_grant && (starve_q != SC_W'(STARVE_MAX))) begin
         starve_d = starve_q + SC_W'(1);
      end
      stall_d = (starve_d == SC_W'(STARVE_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end
`else
   // Strict ALU priority: the stall path is never taken.
   localparam logic STALL_NEVER = (STARVE_MAX < 0);
   assign stall_q = STALL_NEVER;
`endif

   assign bus.lsu_ready = fifo_ready;
   assign bus.lsu_count = count_q;
   assign bus.alu_stall = stall_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vrf_writeback_arb.sv
// Directed bench for vrf_writeback_arb (DATA_W=128, LSU_DEPTH=2, STARVE_MAX=4).
module tb_vrf_writeback_arb;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   vrf_writeback_arb_if #(.DATA_W(128), .CNT_W(2)) bus ();

   vrf_writeback_arb #(.DATA_W(128), .LSU_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iss_valid = 1'b0;
      bus.iss_waddr = '0;
      bus.alu_valid = 1'b0;
      bus.alu_waddr = '0;
      bus.alu_wdata = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_waddr = '0;
      bus.lsu_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0h exp 0", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got %0h exp 0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 128'd0) begin errors++; $display("FAIL reset_rf_wdata got %0h exp 0", bus.rf_wdata); end
      checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
      checks++; if (bus.lsu_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0h exp 0", bus.lsu_count); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", bus.lsu_ready); end
      checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", bus.alu_stall); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu_write();
      logic [127:0] d;
      d = {16{8'hA5}};
      bus.iss_valid = 1'b1;
      bus.iss_waddr = 5'd5;
      tick();
      bus.iss_valid = 1'b0;
      checks++; if (bus.busy !== 32'h0000_0020) begin errors++; $display("FAIL alu_busy_set got %0h exp 20", bus.busy); end
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 5'd5;
      bus.alu_wdata = d;
      tick();
      bus.alu_valid = 1'b0;
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %0h exp 1", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0h exp 5", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== d) begin errors++; $display("FAIL alu_wdata got %0h exp %0h", bus.rf_wdata, d); end
      checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL alu_busy_clear got %0h exp 0", bus.busy); end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_idle got %0h exp 0", bus.rf_we); end
      checks++; if (bus.rf_wdata !== d) begin errors++; $display("FAIL alu_wdata_hold got %0h exp %0h", bus.rf_wdata, d); end
   endtask

   task automatic test_lsu_single();
      logic [127:0] d;
      d = {4{32'hC0DE_0009}};
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL lsu1_ready got %0h exp 1", bus.lsu_ready); end
      bus.lsu_valid = 1'b1;
      bus.lsu_waddr = 5'd9;
      bus.lsu_wdata = d;
      tick();
      bus.lsu_valid = 1'b0;
      checks++; if (bus.lsu_count !== 2'd1) begin errors++; $display("FAIL lsu1_count1 got %0h exp 1", bus.lsu_count); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL lsu1_we_early got %0h exp 0", bus.rf_we); end
      tick();
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL lsu1_we got %0h exp 1", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 5'd9) begin errors++; $display("FAIL lsu1_waddr got %0h exp 9", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== d) begin errors++; $display("FAIL lsu1_wdata got %0h exp %0h", bus.rf_wdata, d); end
      checks++; if (bus.lsu_count !== 2'd0) begin errors++; $display("FAIL lsu1_count0 got %0h exp 0", bus.lsu_count); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] d0, d1, d2, da;
      d0 = {16{8'h10}};
      d1 = {16{8'h11}};
      d2 = {16{8'h12}};
      da = {16{8'hAA}};
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 5'd1;
      bus.alu_wdata = da;
      bus.lsu_valid = 1'b1;
      bus.lsu_waddr = 5'd10;
      bus.lsu_wdata = d0;
      tick();
      checks++; if (bus.lsu_count !== 2'd1) begin errors++; $display("FAIL b2b_count1 got %0h exp 1", bus.lsu_count); end
      bus.lsu_waddr = 5'd11;
      bus.lsu_wdata = d1;
      tick();
      checks++; if (bus.lsu_count !== 2'd2) begin errors++; $display("FAIL b2b_count2 got %0h exp 2", bus.lsu_count); end
      checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0h exp 0", bus.lsu_ready); end
      bus.lsu_waddr = 5'd12;
      bus.lsu_wdata = d2;
      tick();
      checks++; if (bus.lsu_count !== 2'd2) begin errors++; $display("FAIL b2b_held_count got %0h exp 2", bus.lsu_count); end
      checks++; if (bus.rf_waddr !== 5'd1) begin errors++; $display("FAIL b2b_alu_waddr got %0h exp 1", bus.rf_waddr); end
      bus.alu_valid = 1'b0;
      tick();
      checks++; if (bus.rf_waddr !== 5'd10 || bus.rf_wdata !== d0) begin errors++; $display("FAIL b2b_first got %0h/%0h exp a/%0h", bus.rf_waddr, bus.rf_wdata, d0); end
      checks++; if (bus.lsu_count !== 2'd1) begin errors++; $display("FAIL b2b_pop_nopush_count got %0h exp 1", bus.lsu_count); end
      tick();
      bus.lsu_valid = 1'b0;
      checks++; if (bus.rf_waddr !== 5'd11 || bus.rf_wdata !== d1) begin errors++; $display("FAIL b2b_second got %0h/%0h exp b/%0h", bus.rf_waddr, bus.rf_wdata, d1); end
      checks++; if (bus.lsu_count !== 2'd1) begin errors++; $display("FAIL b2b_third_accepted got %0h exp 1", bus.lsu_count); end
      tick();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== d2) begin errors++; $display("FAIL b2b_third got %0h/%0h/%0h exp 1/c/%0h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, d2); end
      checks++; if (bus.lsu_count !== 2'd0) begin errors++; $display("FAIL b2b_drained got %0h exp 0", bus.lsu_count); end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0h exp 0", bus.rf_we); end
   endtask

   task automatic test_set_wins();
      bus.iss_valid = 1'b1;
      bus.iss_waddr = 5'd3;
      tick();
      checks++; if (bus.busy[3] !== 1'b1) begin errors++; $display("FAIL sw_set got %0h exp 1", bus.busy[3]); end
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 5'd3;
      bus.alu_wdata = 128'h3;
      tick();
      bus.iss_valid = 1'b0;
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3) begin errors++; $display("FAIL sw_write got %0h/%0h exp 1/3", bus.rf_we, bus.rf_waddr); end
      checks++; if (bus.busy[3] !== 1'b1) begin errors++; $display("FAIL sw_set_wins got %0h exp 1", bus.busy[3]); end
      tick();
      bus.alu_valid = 1'b0;
      checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL sw_later_clear got %0h exp 0", bus.busy); end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.iss_valid = 1'b1;
      bus.iss_waddr = 5'd7;
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 5'd2;
      bus.alu_wdata = 128'h77;
      bus.lsu_valid = 1'b1;
      bus.lsu_waddr = 5'd20;
      bus.lsu_wdata = 128'h20;
      tick();
      bus.iss_valid = 1'b0;
      bus.lsu_waddr = 5'd21;
      tick();
      checks++; if (bus.lsu_count !== 2'd2 || bus.busy[7] !== 1'b1) begin errors++; $display("FAIL rm_setup got %0h/%0h exp 2/1", bus.lsu_count, bus.busy[7]); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 128'd0) begin errors++; $display("FAIL rm_port_zero got %0h/%0h/%0h exp 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      checks++; if (bus.lsu_count !== 2'd0 || bus.busy !== 32'd0 || bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL rm_state_zero got %0h/%0h/%0h exp 0/0/1", bus.lsu_count, bus.busy, bus.lsu_ready); end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.rf_we !== 1'b0 || bus.lsu_count !== 2'd0) begin errors++; $display("FAIL rm_no_stale cycle %0d got %0h/%0h exp 0/0", i, bus.rf_we, bus.lsu_count); end
      end
   endtask

`ifdef VWB_STARVE_EN
   task automatic test_starve();
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 5'd2;
      bus.alu_wdata = 128'h2;
      bus.lsu_valid = 1'b1;
      bus.lsu_waddr = 5'd20;
      bus.lsu_wdata = 128'h2020;
      tick();
      bus.lsu_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (bus.alu_stall !== 1'b0 || bus.rf_waddr !== 5'd2) begin errors++; $display("FAIL st_lost %0d got %0h/%0h exp 0/2", i, bus.alu_stall, bus.rf_waddr); end
      end
      tick();
      checks++; if (bus.alu_stall !== 1'b1) begin errors++; $display("FAIL st_stall got %0h exp 1", bus.alu_stall); end
      tick();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd20 || bus.rf_wdata !== 128'h2020) begin errors++; $display("FAIL st_forced got %0h/%0h/%0h exp 1/14/2020", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      checks++; if (bus.alu_stall !== 1'b0 || bus.lsu_count !== 2'd0) begin errors++; $display("FAIL st_release got %0h/%0h exp 0/0", bus.alu_stall, bus.lsu_count); end
      tick();
      bus.alu_valid = 1'b0;
      checks++; if (bus.rf_waddr !== 5'd2) begin errors++; $display("FAIL st_alu_resume got %0h exp 2", bus.rf_waddr); end
      tick();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_alu_write();
      test_lsu_single();
      test_back_to_back();
      test_set_wins();
      test_reset_mid();
`ifdef VWB_STARVE_EN
      test_starve();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
